st7701_rgb_timing: RTL and testbench

Generates the RGB parallel video timing (PCLK, HSYNC, VSYNC, DE, 16-bit RGB565 data) for the ST7701 480x480 panel once the SPI init sequencer has configured it (480 lines, VBP 10, VFP 8, COLMOD RGB565). It sits directly downstream of the panel init stage and upstream of the panel pins. It pulls pixels from the frame source over a valid/ready handshake and flags any pixel the source fails to deliver in time.

---
 rtl/st7701_rgb_timing.sv | 189 ++++++++++++++++++
 tb/tb_st7701_rgb_timing.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/st7701_rgb_timing.sv
// Purpose: RGB565 parallel video timing (PCLK/HSYNC/VSYNC/DE/data) for the ST7701 480x480 panel.
// Latency: sync/DE/data registered on the tick (PCLK falling edge), valid 1 clk later; pix_ready/frame_start combinational in the tick cycle.
// Backpressure: none accepted; the panel cannot stall, so a missing pixel is blanked and flagged in the sticky underflow bit.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            run request (sampled every clk in IDLE, only on ticks otherwise)
//   pix_data/valid    RGB565 pixel source; pix_ready pulses for one clk when a pixel is taken
//   frame_start       one-clk pulse on the tick of position (0,0)
//   underflow(_clr)   sticky missing-pixel flag and its clear (set wins)
//   lcd_*             panel pins: pclk, active-low hsync/vsync, active-high de, 16-bit data
module st7701_rgb_timing #(
    parameter int H_ACTIVE = 480,
    parameter int H_SYNC   = 8,
    parameter int H_BP     = 50,
    parameter int H_FP     = 10,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter int V_FP     = 8,
    parameter int PCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr,
    output logic        lcd_pclk,
    output logic        lcd_hsync,
    output logic        lcd_vsync,
    output logic        lcd_de,
    output logic [15:0] lcd_data
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // One extra bit of headroom so the active-region upper bound fits even with a zero porch.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = $clog2(PCLK_DIV);

    localparam logic [DW-1:0] D_LAST = DW'(PCLK_DIV - 1);
    localparam logic [DW-1:0] D_HALF = DW'(PCLK_DIV / 2);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_LO   = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_HI   = HW'(H_SYNC + H_BP + H_ACTIVE);

    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_LO   = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_HI   = VW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] d, d_nxt;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          running;
    logic          tick;
    logic          h_last, v_last, frame_end;
    logic          active_h, active_v, active;

    assign running   = (state != ST_IDLE);
    // Tick is the cycle in which d wraps, i.e. the PCLK falling edge.
    assign tick      = running && (d == D_LAST);
    assign h_last    = (h == H_LAST);
    assign v_last    = (v == V_LAST);
    assign frame_end = h_last && v_last;
    assign active_h  = (h >= H_ACT_LO) && (h < H_ACT_HI);
    assign active_v  = (v >= V_ACT_LO) && (v < V_ACT_HI);
    assign active    = active_h && active_v;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    // DRAIN keeps the counters running so a frame is never cut short;
    // re-raising enable there rejoins RUN on the same timeline.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (tick && !enable) state_nxt = frame_end ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (tick) begin
                    if (enable)         state_nxt = ST_RUN;
                    else if (frame_end) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: combinational outputs ----------------
    always_comb begin
        pix_ready   = tick && active;
        frame_start = tick && (state == ST_RUN) && (h == '0) && (v == '0);
    end

    // ---------------- pixel clock divider ----------------
    always_comb begin
        if (!running || (d == D_LAST)) d_nxt = '0;
        else                           d_nxt = d + DW'(1);
    end

    // lcd_pclk is registered from the next divider value so the pin never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d        <= '0;
            lcd_pclk <= 1'b0;
        end else begin
            d        <= d_nxt;
            lcd_pclk <= (d_nxt >= D_HALF);
        end
    end

    // ---------------- raster position ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (!running) begin
            h <= '0;
            v <= '0;
        end else if (tick) begin
            if (h_last) begin
                h <= '0;
                v <= v_last ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    // ---------------- panel outputs ----------------
    // Registered on the tick for the current position; a missing pixel is sent as black.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_hsync <= 1'b1;
            lcd_vsync <= 1'b1;
            lcd_de    <= 1'b0;
            lcd_data  <= 16'h0000;
        end else if (tick) begin
            lcd_hsync <= (h >= H_SYNC_END);
            lcd_vsync <= (v >= V_SYNC_END);
            lcd_de    <= active;
            lcd_data  <= (active && pix_valid) ? pix_data : 16'h0000;
        end else if (!running) begin
            lcd_hsync <= 1'b1;
            lcd_vsync <= 1'b1;
            lcd_de    <= 1'b0;
            lcd_data  <= 16'h0000;
        end
    end

    // ---------------- underflow flag ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (pix_ready && !pix_valid) begin
            underflow <= 1'b1;
        end else if (underflow_clr) begin
            underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_st7701_rgb_timing.sv
// Purpose: self-checking bench for st7701_rgb_timing using a small raster (8x6 positions, PCLK_DIV 2).
// Latency: expected pixels queued when the source hands one over, compared when the panel output shows it.
// Backpressure: the source can withhold single pixels on request to provoke underflow.
module tb_st7701_rgb_timing;

    localparam int  PD    = 2;
    localparam int  HT    = 8;
    localparam int  VT    = 6;
    localparam int  FT    = HT * VT;
    localparam int  CLK_P = 10;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        frame_start;
    logic        underflow;
    logic        underflow_clr;
    logic        lcd_pclk;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_de;
    logic [15:0] lcd_data;

    st7701_rgb_timing #(
        .H_ACTIVE (4),
        .H_SYNC   (2),
        .H_BP     (1),
        .H_FP     (1),
        .V_ACTIVE (3),
        .V_SYNC   (1),
        .V_BP     (1),
        .V_FP     (1),
        .PCLK_DIV (PD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .frame_start   (frame_start),
        .underflow     (underflow),
        .underflow_clr (underflow_clr),
        .lcd_pclk      (lcd_pclk),
        .lcd_hsync     (lcd_hsync),
        .lcd_vsync     (lcd_vsync),
        .lcd_de        (lcd_de),
        .lcd_data      (lcd_data)
    );

    initial clk = 1'b0;
    always #(CLK_P / 2) clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    // source state
    int          pix_idx     = 0;
    int          drop_idx    = -1;
    bit          clr_on_drop = 1'b0;
    int          clr_req_cnt = 0;
    int          clr_done_cnt = 0;
    logic [15:0] src         = 16'h0000;
    bit          src_adv     = 1'b0;

    // monitor state
    bit          anchored = 1'b0;
    int          pos      = 0;
    int          cur      = 0;
    bit          pending  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Active window of the small raster: h 3..6, v 2..4.
    function automatic bit exp_active(input int p);
        int hh;
        int vv;
        hh = p % HT;
        vv = p / HT;
        return (hh >= 3) && (hh <= 6) && (vv >= 2) && (vv <= 4);
    endfunction

    // ---------------- pixel source ----------------
    // Data counts 0,1,2,... and only advances when a pixel is really taken.
    initial begin
        underflow_clr = 1'b0;
        pix_valid     = 1'b1;
        pix_data      = src;
        forever begin
            @(negedge clk);
            underflow_clr = 1'b0;
            if (src_adv) begin
                pix_valid = (pix_idx != drop_idx);
                pix_data  = pix_valid ? src : 16'hBAD0;
                src_adv   = 1'b0;
            end
            if (clr_req_cnt != clr_done_cnt) begin
                underflow_clr = 1'b1;
                clr_done_cnt  = clr_req_cnt;
            end
            if (pix_ready === 1'b1) begin
                exp_q.push_back(pix_valid ? pix_data : 16'h0000);
                if (pix_valid) src = src + 16'd1;
                else if (clr_on_drop) underflow_clr = 1'b1;
                pix_idx++;
                src_adv = 1'b1;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    // With PCLK_DIV 2 every clk with lcd_pclk high is a tick; outputs for that
    // position appear one clk later when lcd_pclk has fallen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                anchored = 1'b0;
                pending  = 1'b0;
            end else if (lcd_pclk) begin
                if (!anchored && frame_start) begin
                    anchored = 1'b1;
                    pos      = 0;
                end
                if (anchored) begin
                    chk("frame_start_pos", frame_start, (pos == 0));
                    chk("pix_ready_pos", pix_ready, exp_active(pos));
                    cur     = pos;
                    pos     = (pos + 1) % FT;
                    pending = 1'b1;
                end
            end else begin
                chk("no_stray_pulse", {pix_ready, frame_start}, 0);
                if (pending) begin
                    chk("hsync", lcd_hsync, ((cur % HT) >= 2));
                    chk("vsync", lcd_vsync, ((cur / HT) >= 1));
                    chk("de", lcd_de, exp_active(cur));
                    if (lcd_de) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL lcd_data: got 0x%0h with no pixel queued", lcd_data);
                        end else begin
                            chk("lcd_data", lcd_data, exp_q.pop_front());
                        end
                    end else begin
                        chk("lcd_data_blank", lcd_data, 0);
                    end
                    pending = 1'b0;
                end
            end
        end
    end

    task automatic wait_fs(input string name, output time t);
        bit seen;
        seen = 1'b0;
        t    = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (frame_start) begin
                seen = 1'b1;
                t    = $time;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_pix(input int target);
        for (int n = 0; n < 400 && pix_idx <= target; n++) @(negedge clk);
        chk("pix_reached", (pix_idx > target), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pclk"},        lcd_pclk,    0);
        chk({tag, "_hsync"},       lcd_hsync,   1);
        chk({tag, "_vsync"},       lcd_vsync,   1);
        chk({tag, "_de"},          lcd_de,      0);
        chk({tag, "_data"},        lcd_data,    0);
        chk({tag, "_pix_ready"},   pix_ready,   0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_underflow"},   underflow,   0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time t0;
        time t1;
        int  bad;
        int  lat;
        int  n_rdy, n_hs, n_vs, n_de, n_fs, n_pclk;
        bit  fs_end;

        rst    = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // enable low: nothing moves
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (lcd_pclk !== 1'b0 || lcd_hsync !== 1'b1 || lcd_vsync !== 1'b1 ||
                lcd_de !== 1'b0 || pix_ready !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // first tick (with frame_start) PCLK_DIV clk after enable is sampled
        enable = 1'b1;
        lat    = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_start) begin
                lat = k;
                break;
            end
        end
        chk("first_frame_latency", lat, PD);

        // two full frames: per-frame pulse and level counts
        for (int f = 0; f < 2; f++) begin
            n_rdy = 0; n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; fs_end = 1'b0;
            for (int k = 1; k <= FT * PD; k++) begin
                @(negedge clk);
                if (pix_ready) n_rdy++;
                if (!lcd_hsync) n_hs++;
                if (!lcd_vsync) n_vs++;
                if (lcd_de) n_de++;
                if (k < FT * PD && frame_start) n_fs++;
                if (k == FT * PD) fs_end = frame_start;
            end
            chk("ready_per_frame", n_rdy, 12);
            chk("hsync_low_clks", n_hs, 24);
            chk("vsync_low_clks", n_vs, 16);
            chk("de_high_clks", n_de, 24);
            chk("frame_start_early", n_fs, 0);
            chk("frame_start_period", fs_end, 1);
        end

        // underflow: set, clear, and set winning over a simultaneous clear
        chk("underflow_idle", underflow, 0);
        drop_idx = pix_idx + 5;
        wait_pix(drop_idx);
        chk("underflow_set", underflow, 1);
        clr_req_cnt++;
        repeat (3) @(negedge clk);
        chk("underflow_cleared", underflow, 0);
        clr_on_drop = 1'b1;
        drop_idx    = pix_idx + 3;
        wait_pix(drop_idx);
        chk("underflow_set_beats_clr", underflow, 1);
        clr_on_drop = 1'b0;
        drop_idx    = -1;

        // enable dropped then re-raised inside a frame: no gap
        wait_fs("fs_before_reraise", t0);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        enable = 1'b1;
        wait_fs("fs_after_reraise", t1);
        chk("reraise_frame_period", int'(t1 - t0), FT * PD * CLK_P);

        // enable dropped mid-frame: the frame completes, then idle
        wait_fs("fs_before_drain", t0);
        n_rdy = 0; n_fs = 0; n_pclk = 0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (k == 30) enable = 1'b0;
            if (pix_ready) n_rdy++;
            if (frame_start) n_fs++;
            if (k > 110 && lcd_pclk) n_pclk++;
        end
        chk("drain_ready_count", n_rdy, 12);
        chk("drain_no_new_frame", n_fs, 0);
        chk("drain_pclk_stopped", n_pclk, 0);
        chk("drain_end_pos", pos, 0);
        chk("drain_idle_hsync", lcd_hsync, 1);
        chk("drain_idle_vsync", lcd_vsync, 1);

        // asynchronous reset mid-frame during active video
        enable = 1'b1;
        wait_fs("fs_before_reset", t0);
        for (int n = 0; n < 200 && !lcd_de; n++) @(negedge clk);
        chk("de_seen_before_reset", lcd_de, 1);
        chk("underflow_before_reset", underflow, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (frame_start) begin
                lat = k;
                break;
            end
        end
        chk("restart_latency", lat, PD);
        repeat (FT * PD) @(negedge clk);
        chk("underflow_after_restart", underflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
